alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL: start  input  1  request; sampled only in IDLE.
REQ-004 SHALL: A  input  32  operand A, from the operand-select stage.
REQ-005 SHALL: B  input  32  operand B, from the operand-select stage.
REQ-006 SHALL: ALU_OP  input  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLT, 111 SLL.
REQ-007 SHALL: F  output  32  registered result.
REQ-008 SHALL: ZF  output  1  registered zero flag.
REQ-009 SHALL: OF  output  1  registered signed-overflow flag.
REQ-010 SHALL: CF  output  1  registered carry/borrow flag.
REQ-011 SHALL: busy  output  1  high in any state except IDLE.
REQ-012 SHALL: done  output  1  one-cycle pulse when F and flags update.

Function
REQ-013 SHALL: FSM states IDLE, EXEC, SHIFT; no other state is reachable.
REQ-014 SHALL: In IDLE, start=1 latches A, B and ALU_OP into internal registers. Next state is SHIFT if ALU_OP=111, otherwise EXEC.
REQ-015 SHALL: EXEC computes from the latched operands, writes F/ZF/OF/CF, pulses done, then returns to IDLE. done is high on the cycle after the 2nd edge counted from the start-sampling edge.
REQ-016 SHALL: On SHIFT entry, load shreg=A and cnt=B[4:0]. Each SHIFT cycle with cnt!=0: shreg<<=1 (zero fill) and cnt--. With cnt==0: F=shreg, done pulse, go to IDLE. Shift by n yields done after n+2 edges including the start edge.
REQ-017 SHALL: Logic ops operate bitwise on 32 bits.
REQ-018 SHALL: ADD computes the 33-bit sum A+B. F=sum[31:0], CF=sum[32], OF=(A[31]==B[31])&&(F[31]!=A[31]).
REQ-019 SHALL: SUB computes F=A-B. CF=1 iff A<B unsigned (borrow). OF=(A[31]!=B[31])&&(F[31]!=A[31]).
REQ-020 SHALL: SLT sets F=32'h1 if A<B signed, else 0.
REQ-021 SHALL: OF=0 and CF=0 for all ops other than ADD and SUB.
REQ-022 SHALL: ZF=(F==0) for every op.
REQ-023 SHALL: F and flags hold their values between completions; done is low except in the completion cycle.
REQ-024 SHALL: start while busy=1 is ignored, is not queued, and does not disturb latched operands.
REQ-025 SHALL: Changes on A/B/ALU_OP after the start-sampling edge do not affect the in-flight result.
REQ-026 SHALL: start held high continuously launches a new operation on each return to IDLE. This gives one IDLE cycle between operations.

Reset
REQ-027 SHALL: rst=1 forces state=IDLE, F=0, ZF=1, OF=0, CF=0, busy=0, done=0, and cnt/shreg=0 at the next edge.
REQ-028 SHALL: rst wins over start when both are high. Reset during EXEC or SHIFT aborts the operation with no done pulse, and F keeps its reset value.

Verification
REQ-029 SHALL: A=7FFFFFFF, B=7FFFFFFF, ADD -> F=FFFFFFFE, OF=1, CF=0, ZF=0, done 2 edges after start edge.
REQ-030 SHALL: A=80000000, B=80000000, ADD -> F=00000000, ZF=1, OF=1, CF=1.
REQ-031 SHALL: A=80000000, B=FFFFFFFF, SUB -> F=80000001, CF=1, OF=0. Same operands with SLT -> F=00000001.
REQ-032 SHALL: A=00000003, B=00000607, SLL (shift amount 7) -> F=00000180, busy high for 8 cycles, done 9 edges after start edge. Second start pulse mid-shift ignored.
REQ-033 SHALL: A=FFFFFFFF, B=FFFFFFFF, XOR -> F=0, ZF=1, OF=0, CF=0. NOR with A=B=0 -> F=FFFFFFFF, ZF=0.
REQ-034 SHALL: Start SLL with B=0000001F and assert rst after 5 cycles -> busy=0 and F=0 next edge, no done pulse. A following ADD with A=B=0 completes normally with ZF=1.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Multi-cycle 32-bit ALU with latched operands, registered result
//            and flags, and a one-bit-per-cycle serial left shifter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALU_OP,
    output logic [31:0] F,
    output logic        ZF,
    output logic        OF,
    output logic        CF,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_XOR = 3'b010;
    localparam logic [2:0] c_OP_NOR = 3'b011;
    localparam logic [2:0] c_OP_ADD = 3'b100;
    localparam logic [2:0] c_OP_SUB = 3'b101;
    localparam logic [2:0] c_OP_SLT = 3'b110;
    localparam logic [2:0] c_OP_SLL = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_op;
    logic [31:0] r_shreg;
    logic [4:0]  r_cnt;
    logic [31:0] r_f;
    logic        r_zf;
    logic        r_of;
    logic        r_cf;
    logic        r_done;

    logic [32:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_f;
    logic        w_of;
    logic        w_cf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (ALU_OP == c_OP_SLL) ? SHIFT : EXEC;
                end
            end
            EXEC:    w_state_nxt = IDLE;
            SHIFT: begin
                if (r_cnt == 5'd0) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Single-cycle result path, evaluated only from the latched operands.
    always_comb begin
        w_sum  = {1'b0, r_a} + {1'b0, r_b};
        w_diff = r_a - r_b;
        w_f    = 32'd0;
        w_of   = 1'b0;
        w_cf   = 1'b0;
        case (r_op)
            c_OP_AND: w_f = r_a & r_b;
            c_OP_OR:  w_f = r_a | r_b;
            c_OP_XOR: w_f = r_a ^ r_b;
            c_OP_NOR: w_f = ~(r_a | r_b);
            c_OP_ADD: begin
                w_f  = w_sum[31:0];
                w_cf = w_sum[32];
                w_of = (r_a[31] == r_b[31]) && (w_sum[31] != r_a[31]);
            end
            c_OP_SUB: begin
                w_f  = w_diff;
                w_cf = (r_a < r_b);
                w_of = (r_a[31] != r_b[31]) && (w_diff[31] != r_a[31]);
            end
            c_OP_SLT: w_f = {31'd0, ($signed(r_a) < $signed(r_b))};
            default:  w_f = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 3'd0;
            r_shreg <= 32'd0;
            r_cnt   <= 5'd0;
            r_f     <= 32'd0;
            r_zf    <= 1'b1;
            r_of    <= 1'b0;
            r_cf    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a  <= A;
                        r_b  <= B;
                        r_op <= ALU_OP;
                        // Shifter is primed on the launch edge so the first
                        // SHIFT cycle can already move a bit.
                        if (ALU_OP == c_OP_SLL) begin
                            r_shreg <= A;
                            r_cnt   <= B[4:0];
                        end
                    end
                end
                EXEC: begin
                    r_f    <= w_f;
                    r_zf   <= (w_f == 32'd0);
                    r_of   <= w_of;
                    r_cf   <= w_cf;
                    r_done <= 1'b1;
                end
                SHIFT: begin
                    if (r_cnt != 5'd0) begin
                        r_shreg <= {r_shreg[30:0], 1'b0};
                        r_cnt   <= r_cnt - 5'd1;
                    end else begin
                        r_f    <= r_shreg;
                        r_zf   <= (r_shreg == 32'd0);
                        r_of   <= 1'b0;
                        r_cf   <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

    assign F    = r_f;
    assign ZF   = r_zf;
    assign OF   = r_of;
    assign CF   = r_cf;
    assign done = r_done;
    assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Self-checking bench for alu_seq: directed vector table, random
//            ops against a reference model, and multi-cycle corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALU_OP;
    logic [31:0] F;
    logic        ZF;
    logic        OF;
    logic        CF;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    alu_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .B      (B),
        .ALU_OP (ALU_OP),
        .F      (F),
        .ZF     (ZF),
        .OF     (OF),
        .CF     (CF),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] f;
        logic        zf;
        logic        of;
        logic        cf;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: results derived from plain arithmetic on wide integers.
    function automatic vec_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        vec_t        r;
        longint      s;
        logic [63:0] u;
        r.a = a; r.b = b; r.op = op;
        r.f = 32'd0; r.of = 1'b0; r.cf = 1'b0; r.lat = 2;
        case (op)
            3'd0: r.f = a & b;
            3'd1: r.f = a | b;
            3'd2: r.f = a ^ b;
            3'd3: r.f = ~(a | b);
            3'd4: begin
                u    = {32'd0, a} + {32'd0, b};
                r.f  = u[31:0];
                r.cf = (u > 64'hFFFF_FFFF);
                s    = longint'($signed(a)) + longint'($signed(b));
                r.of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd5: begin
                r.f  = a - b;
                r.cf = (a < b);
                s    = longint'($signed(a)) - longint'($signed(b));
                r.of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd6: r.f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin
                r.f   = a << b[4:0];
                r.lat = int'(b[4:0]) + 2;
            end
        endcase
        r.zf = (r.f == 32'd0);
        return r;
    endfunction

    // Launch one op; lat counts edges from the start edge up to done.
    task automatic run_op(input vec_t v, input string tag);
        int lat;
        int busyc;
        @(negedge clk);
        A = v.a; B = v.b; ALU_OP = v.op; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = $urandom; B = $urandom; ALU_OP = 3'($urandom);
        lat = 1; busyc = 0;
        while (!done && lat < 64) begin
            if (busy) busyc++;
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"}, lat, v.lat);
        chk({tag, ".F"},   F,   v.f);
        chk({tag, ".ZF"},  ZF,  v.zf);
        chk({tag, ".OF"},  OF,  v.of);
        chk({tag, ".CF"},  CF,  v.cf);
        chk({tag, ".busy_cycles"}, busyc, v.lat - 1);
        @(negedge clk);
        chk({tag, ".done_pulse"}, done, 1'b0);
    endtask

    vec_t vecs[11];
    vec_t rv;

    initial begin
        int n;
        bit seen_done;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; ALU_OP = '0;

        vecs[0]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 3'd4, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 2};
        vecs[1]  = '{32'h80000000, 32'h80000000, 3'd4, 32'h00000000, 1'b1, 1'b1, 1'b1, 2};
        vecs[2]  = '{32'h80000000, 32'hFFFFFFFF, 3'd5, 32'h80000001, 1'b0, 1'b0, 1'b1, 2};
        vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 3'd6, 32'h00000001, 1'b0, 1'b0, 1'b0, 2};
        vecs[4]  = '{32'h00000003, 32'h00000607, 3'd7, 32'h00000180, 1'b0, 1'b0, 1'b0, 9};
        vecs[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2, 32'h00000000, 1'b1, 1'b0, 1'b0, 2};
        vecs[6]  = '{32'h00000000, 32'h00000000, 3'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 2};
        vecs[7]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 3'd0, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 2};
        vecs[8]  = '{32'h12340000, 32'h00005678, 3'd1, 32'h12345678, 1'b0, 1'b0, 1'b0, 2};
        vecs[9]  = '{32'hDEADBEEF, 32'h00000020, 3'd7, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 2};
        vecs[10] = '{32'h00000001, 32'h0000001F, 3'd7, 32'h80000000, 1'b0, 1'b0, 1'b0, 33};

        repeat (2) @(negedge clk);
        chk("reset.F", F, 32'd0);
        chk("reset.ZF", ZF, 1'b1);
        chk("reset.OF", OF, 1'b0);
        chk("reset.CF", CF, 1'b0);
        chk("reset.busy", busy, 1'b0);
        chk("reset.done", done, 1'b0);

        // Reset wins over a simultaneous start, which is not queued.
        start = 1'b1; A = 32'd1; B = 32'd2; ALU_OP = 3'd4;
        @(negedge clk);
        chk("rst_start.busy", busy, 1'b0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start.busy_after", busy, 1'b0);

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            rv = model($urandom, $urandom, 3'($urandom));
            run_op(rv, $sformatf("rnd%0d", i));
        end

        // Start held high: 5+6 then 9-4 with exactly one IDLE cycle between.
        @(negedge clk);
        A = 32'd5; B = 32'd6; ALU_OP = 3'd4; start = 1'b1;
        @(negedge clk);
        A = 32'd9; B = 32'd4; ALU_OP = 3'd5;
        @(negedge clk);
        chk("held.done1", done, 1'b1);
        chk("held.F1", F, 32'd11);
        chk("held.idle", busy, 1'b0);
        @(negedge clk);
        chk("held.busy2", busy, 1'b1);
        chk("held.done_low", done, 1'b0);
        start = 1'b0;
        @(negedge clk);
        chk("held.done2", done, 1'b1);
        chk("held.F2", F, 32'd5);

        // Second start mid-shift with new operands must be ignored.
        @(negedge clk);
        A = 32'h3; B = 32'h607; ALU_OP = 3'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; n = 1;
        while (!done && n < 64) begin
            if (n == 3) begin start = 1'b1; A = 32'hFFFFFFFF; B = 32'd0; ALU_OP = 3'd4; end
            if (n == 4) start = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("midstart.lat", n, 9);
        chk("midstart.F", F, 32'h180);
        seen_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        chk("midstart.not_queued", seen_done, 1'b0);

        // Reset during a long shift: abort, no done, F returns to zero.
        A = 32'h1; B = 32'h1F; ALU_OP = 3'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; seen_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.busy", busy, 1'b0);
        chk("abort.F", F, 32'd0);
        chk("abort.ZF", ZF, 1'b1);
        chk("abort.done", done, 1'b0);
        repeat (3) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        chk("abort.no_done", seen_done, 1'b0);
        run_op(model(32'd0, 32'd0, 3'd4), "post_abort_add");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
